// File: rtl/adder_sched_pkg.sv
// Shared definitions for the round-robin adder scheduler: FSM encoding and default sizes.
package adder_sched_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/adder_rr_scheduler_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping. Purely combinational.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Walk the requesters starting from ptr; the first hit wins and masks later ones.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one registered CLA adder between NREQ requesters with round-robin arbitration
// and a valid/ready response port tagged with the owning requester index.
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              add_ce,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_s,
    input  logic              add_cout
);

    sched_state_t    state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  op_id;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any_valid;
    logic            take;
    logic            capture;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (any_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is masked by rst_n so no handshake can appear while reset is held.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        add_ce    = 1'b0;
        take      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid && rst_n) begin
                    req_ready = grant;
                    take      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                add_ce    = 1'b1;
                state_nxt = CAPT;
            end
            CAPT: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);

    // Operands stay on the adder inputs from the grant until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
            op_id   <= '0;
            rr_ptr  <= '0;
        end else if (take) begin
            add_a   <= req_a[grant_idx*W +: W];
            add_b   <= req_b[grant_idx*W +: W];
            add_cin <= req_cin[grant_idx];
            op_id   <= grant_idx;
            rr_ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
        end else if (capture) begin
            rsp_sum  <= add_s;
            rsp_cout <= add_cout;
            rsp_id   <= op_id;
        end
    end

endmodule
